// File: rtl/result_drain_arbiter.sv
// -----------------------------------------------------------------------------
// result_drain_arbiter
//
// Round-robin arbiter that shares one result packer between NUM_SRC engine
// result FIFOs. Each engine posts a drain request carrying the number of
// 16-bit results its command produced. The arbiter grants one source at a
// time and forwards exactly that many words through a FIFO-shaped port. It
// then pulses completion, so consecutive commands land contiguously in the
// result BRAM.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_src_fifo_rdata      head word of each source FIFO (source s at [s*16 +: 16])
//   i_src_fifo_empty      per-source FIFO empty
//   o_src_fifo_ren        per-source pop strobe
//   i_req_valid           per-source drain request valid
//   i_req_count           per-source word count (source s at [s*CNT_W +: CNT_W])
//   o_req_ready           per-source: no request pending
//   o_fifo_rdata          word presented to the packer
//   o_fifo_empty          no word available to the packer
//   i_fifo_ren            packer pop strobe
//   i_almost_full         packer/BRAM almost full, stalls forwarding
//   o_done_valid          one-cycle completion pulse
//   o_done_src            source index of the completed request
//   o_grant_src           currently granted source (meaningful while o_busy)
//   o_busy                arbiter is not idle
// -----------------------------------------------------------------------------
module result_drain_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_SRC*16-1:0]    i_src_fifo_rdata,
    input  logic [NUM_SRC-1:0]       i_src_fifo_empty,
    output logic [NUM_SRC-1:0]       o_src_fifo_ren,
    input  logic [NUM_SRC-1:0]       i_req_valid,
    input  logic [NUM_SRC*CNT_W-1:0] i_req_count,
    output logic [NUM_SRC-1:0]       o_req_ready,
    output logic [15:0]              o_fifo_rdata,
    output logic                     o_fifo_empty,
    input  logic                     i_fifo_ren,
    input  logic                     i_almost_full,
    output logic                     o_done_valid,
    output logic [1:0]               o_done_src,
    output logic [1:0]               o_grant_src,
    output logic                     o_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   count_q [NUM_SRC];
    logic [CNT_W-1:0]   count_d [NUM_SRC];
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_grant_q, last_grant_d;

    logic [NUM_SRC-1:0] accept;
    logic               pick_found;
    logic [1:0]         pick_src;
    logic [2:0]         cand;
    logic [CNT_W-1:0]   pick_count;
    logic [15:0]        sel_rdata;
    logic               sel_empty;
    logic               xfer;

    assign accept      = i_req_valid & ~pending_q;
    assign o_req_ready = ~pending_q;

    // Round-robin pick: first pending source starting after last_grant.
    // The final candidate wraps back to last_grant itself.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a signal unassigned and infers a latch.
        pick_found = 1'b0;
        pick_src   = '0;
        pick_count = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = 3'(last_grant_q) + 3'(i);
            if (cand >= 3'(NUM_SRC)) begin
                cand = cand - 3'(NUM_SRC);
            end
            for (int s = 0; s < NUM_SRC; s++) begin
                if (!pick_found && cand == 3'(s) && pending_q[s]) begin
                    pick_found = 1'b1;
                    pick_src   = 2'(s);
                    pick_count = count_q[s];
                end
            end
        end
    end

    // Granted-source mux.
    always_comb begin
        sel_rdata = '0;
        sel_empty = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (grant_q == 2'(s)) begin
                sel_rdata = i_src_fifo_rdata[s*16 +: 16];
                sel_empty = i_src_fifo_empty[s];
            end
        end
    end

    // Packer-side port: only live in DRAIN. A pop attempt against an empty
    // (or stalled) port is ignored, so xfer is the one true transfer strobe.
    always_comb begin
        o_fifo_rdata   = '0;
        o_fifo_empty   = 1'b1;
        o_src_fifo_ren = '0;
        xfer           = 1'b0;
        if (state_q == ST_DRAIN) begin
            o_fifo_rdata = sel_rdata;
            o_fifo_empty = sel_empty || i_almost_full;
            xfer         = i_fifo_ren && !o_fifo_empty;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (grant_q == 2'(s)) begin
                    o_src_fifo_ren[s] = xfer;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | accept;
        remaining_d  = remaining_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        for (int s = 0; s < NUM_SRC; s++) begin
            count_d[s] = accept[s] ? i_req_count[s*CNT_W +: CNT_W] : count_q[s];
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_src;
                    remaining_d = pick_count;
                    state_d     = (pick_count == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // pending stays set through DONE, so a same-cycle repost from
                // the granted source is held off until the following cycle.
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (grant_q == 2'(s)) begin
                        pending_d[s] = 1'b0;
                    end
                end
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_done_valid = (state_q == ST_DONE);
    assign o_done_src   = (state_q == ST_DONE) ? grant_q : 2'd0;
    assign o_grant_src  = grant_q;
    assign o_busy       = (state_q != ST_IDLE);

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (i_reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            remaining_q  <= '0;
            grant_q      <= '0;
            last_grant_q <= 2'(NUM_SRC - 1);
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            remaining_q  <= remaining_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: the per-source count registers are left out of reset; a count is
    // only read while its pending flag is set, and pending is reset.
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            count_q[s] <= count_d[s];
        end
    end

endmodule

// File: tb/tb_result_drain_arbiter.sv
// -----------------------------------------------------------------------------
// tb_result_drain_arbiter
//
// Directed bench for result_drain_arbiter with three sources. Source FIFOs are
// modelled as arrays with read/write pointers; a negedge monitor records every
// word the packer accepts, every source pop and every done pulse.
// -----------------------------------------------------------------------------
module tb_result_drain_arbiter;

    localparam int NUM_SRC = 3;
    localparam int CNT_W   = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_SRC*16-1:0]    src_rdata;
    logic [NUM_SRC-1:0]       src_empty;
    logic [NUM_SRC-1:0]       src_ren;
    logic [NUM_SRC-1:0]       req_valid;
    logic [NUM_SRC*CNT_W-1:0] req_count;
    logic [NUM_SRC-1:0]       req_ready;
    logic [15:0]              fifo_rdata;
    logic                     fifo_empty;
    logic                     fifo_ren;
    logic                     almost_full;
    logic                     done_valid;
    logic [1:0]               done_src;
    logic [1:0]               grant_src;
    logic                     busy;

    always #5 clk = ~clk;

    result_drain_arbiter #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_src_fifo_rdata (src_rdata),
        .i_src_fifo_empty (src_empty),
        .o_src_fifo_ren   (src_ren),
        .i_req_valid      (req_valid),
        .i_req_count      (req_count),
        .o_req_ready      (req_ready),
        .o_fifo_rdata     (fifo_rdata),
        .o_fifo_empty     (fifo_empty),
        .i_fifo_ren       (fifo_ren),
        .i_almost_full    (almost_full),
        .o_done_valid     (done_valid),
        .o_done_src       (done_src),
        .o_grant_src      (grant_src),
        .o_busy           (busy)
    );

    // Source FIFO model: mem/wr_ptr written by the stimulus, rd_ptr by the pop logic.
    logic [15:0] mem [NUM_SRC][256];
    int          wr_ptr [NUM_SRC];
    int          rd_ptr [NUM_SRC];

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_empty[s]           = (rd_ptr[s] == wr_ptr[s]);
            src_rdata[s*16 +: 16]  = mem[s][rd_ptr[s][7:0]];
        end
    end

    always @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_ren[s]) rd_ptr[s] <= rd_ptr[s] + 1;
        end
    end

    // Monitor.
    logic [15:0] got [$];
    int          done_q [$];
    int          pop_cnt [NUM_SRC];

    always @(negedge clk) begin
        if (fifo_ren && !fifo_empty) got.push_back(fifo_rdata);
        if (done_valid) done_q.push_back(int'(done_src));
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_ren[s]) pop_cnt[s]++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int s, input logic [15:0] w);
        mem[s][wr_ptr[s] % 256] = w;
        wr_ptr[s]++;
    endtask

    task automatic post(input logic [NUM_SRC-1:0] mask, input int c0, input int c1, input int c2);
        req_valid = mask;
        req_count = {CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
        tick();
        req_valid = '0;
    endtask

    task automatic wait_done(input int target, input string name);
        int c = 0;
        while (done_q.size() < target && c < 200) begin
            tick();
            c++;
        end
        check(name, 32'(done_q.size() >= target), 32'd1);
    endtask

    function automatic logic [15:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 16'hxxxx;
    endfunction

    function automatic int done_at(input int i);
        return (i < done_q.size()) ? done_q[i] : -1;
    endfunction

    // {src_ren, req_ready, fifo_empty, fifo_rdata, done_valid, done_src, grant_src, busy}
    localparam logic [28:0] IDLE_VEC = {3'b000, 3'b111, 1'b1, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b0};

    task automatic check_idle(input string name);
        check(name, 32'({src_ren, req_ready, fifo_empty, fifo_rdata, done_valid, done_src, grant_src, busy}),
              32'(IDLE_VEC));
    endtask

    typedef struct {
        int               src;
        int               count;
        int               nload;
        logic [5:0][15:0] ld;
        int               fwd;
        logic [5:0][15:0] ex;
        int               left;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int g0, d0, p0, p1;
        int s;

        vecs[0] = '{src:0, count:1, nload:1, ld:{80'h0, 16'h253e}, fwd:1, ex:{80'h0, 16'h253e}, left:0};
        vecs[1] = '{src:0, count:4, nload:4, ld:{32'h0, 16'ha40a, 16'ha390, 16'h25b7, 16'h22f7},
                    fwd:4, ex:{32'h0, 16'ha40a, 16'ha390, 16'h25b7, 16'h22f7}, left:0};
        vecs[2] = '{src:0, count:4, nload:6,
                    ld:{16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
                    fwd:4, ex:{32'h0, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, left:2};
        vecs[3] = '{src:0, count:2, nload:0, ld:96'h0, fwd:2, ex:{64'h0, 16'h6666, 16'h5555}, left:0};
        vecs[4] = '{src:2, count:3, nload:3, ld:{48'h0, 16'h8000, 16'h0001, 16'hbeef},
                    fwd:3, ex:{48'h0, 16'h8000, 16'h0001, 16'hbeef}, left:0};
        vecs[5] = '{src:1, count:0, nload:1, ld:{80'h0, 16'h7777}, fwd:0, ex:96'h0, left:1};
        vecs[6] = '{src:1, count:1, nload:0, ld:96'h0, fwd:1, ex:{80'h0, 16'h7777}, left:0};

        reset       = 1'b1;
        req_valid   = '0;
        req_count   = '0;
        fifo_ren    = 1'b1;
        almost_full = 1'b0;
        tick();
        tick();
        check_idle("reset_in");
        reset = 1'b0;
        tick();
        check_idle("reset_out");

        // Table-driven single requests, back to back without reset.
        for (int v = 0; v < 7; v++) begin
            s  = vecs[v].src;
            g0 = got.size();
            d0 = done_q.size();
            p0 = pop_cnt[s];
            for (int k = 0; k < vecs[v].nload; k++) load(s, vecs[v].ld[k]);
            check($sformatf("v%0d ready", v), 32'(req_ready[s]), 32'd1);
            post(NUM_SRC'(1) << s, (s == 0) ? vecs[v].count : 0,
                 (s == 1) ? vecs[v].count : 0, (s == 2) ? vecs[v].count : 0);
            wait_done(d0 + 1, $sformatf("v%0d done_seen", v));
            repeat (3) tick();
            check($sformatf("v%0d nwords", v), 32'(got.size() - g0), 32'(vecs[v].fwd));
            for (int k = 0; k < vecs[v].fwd; k++)
                check($sformatf("v%0d word%0d", v, k), 32'(got_at(g0 + k)), 32'(vecs[v].ex[k]));
            check($sformatf("v%0d ndone", v), 32'(done_q.size() - d0), 32'd1);
            check($sformatf("v%0d done_src", v), 32'(done_at(d0)), 32'(s));
            check($sformatf("v%0d pops", v), 32'(pop_cnt[s] - p0), 32'(vecs[v].fwd));
            check($sformatf("v%0d left", v), 32'(wr_ptr[s] - rd_ptr[s]), 32'(vecs[v].left));
            check($sformatf("v%0d idle", v), 32'(busy), 32'd0);
        end

        // Simultaneous pair after src1 was served last: src0 wins first.
        g0 = got.size();
        d0 = done_q.size();
        load(0, 16'hc0a1); load(0, 16'hc0a2);
        load(1, 16'hc1b1); load(1, 16'hc1b2);
        post(3'b011, 2, 2, 0);
        check("pair1 ready_held", 32'(req_ready), 32'(3'b100));
        wait_done(d0 + 2, "pair1 done_seen");
        repeat (3) tick();
        check("pair1 nwords", 32'(got.size() - g0), 32'd4);
        check("pair1 w0", 32'(got_at(g0)),     32'h0000c0a1);
        check("pair1 w1", 32'(got_at(g0 + 1)), 32'h0000c0a2);
        check("pair1 w2", 32'(got_at(g0 + 2)), 32'h0000c1b1);
        check("pair1 w3", 32'(got_at(g0 + 3)), 32'h0000c1b2);
        check("pair1 done0", 32'(done_at(d0)),     32'd0);
        check("pair1 done1", 32'(done_at(d0 + 1)), 32'd1);

        // Serve src0 alone, then a new pair must start with src1.
        d0 = done_q.size();
        load(0, 16'h0d0d);
        post(3'b001, 1, 0, 0);
        wait_done(d0 + 1, "solo0 done_seen");
        repeat (2) tick();
        g0 = got.size();
        d0 = done_q.size();
        load(0, 16'hee01);
        load(1, 16'hff01);
        post(3'b011, 1, 1, 0);
        wait_done(d0 + 2, "pair2 done_seen");
        repeat (3) tick();
        check("pair2 w0", 32'(got_at(g0)),     32'h0000ff01);
        check("pair2 w1", 32'(got_at(g0 + 1)), 32'h0000ee01);
        check("pair2 done0", 32'(done_at(d0)),     32'd1);
        check("pair2 done1", 32'(done_at(d0 + 1)), 32'd0);

        // almost_full stall in the middle of an 8-word drain.
        g0 = got.size();
        d0 = done_q.size();
        p0 = pop_cnt[0];
        for (int k = 0; k < 8; k++) load(0, 16'h0b00 + 16'(k));
        post(3'b001, 8, 0, 0);
        tick();
        check("af first_busy",  32'(busy),       32'd1);
        check("af first_grant", 32'(grant_src),  32'd0);
        check("af first_avail", 32'(fifo_empty), 32'd0);
        check("af first_word",  32'(fifo_rdata), 32'h00000b00);
        tick();
        tick();
        almost_full = 1'b1;
        #1;
        p1 = pop_cnt[0];
        check("af pops_before", 32'(p1 - p0), 32'd2);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("af stall%0d empty", c), 32'(fifo_empty), 32'd1);
            check($sformatf("af stall%0d ren", c),   32'(src_ren),    32'd0);
            check($sformatf("af stall%0d busy", c),  32'(busy),       32'd1);
            tick();
        end
        check("af no_pop_in_stall", 32'(pop_cnt[0] - p1), 32'd0);
        almost_full = 1'b0;
        wait_done(d0 + 1, "af done_seen");
        repeat (3) tick();
        check("af nwords", 32'(got.size() - g0), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("af word%0d", k), 32'(got_at(g0 + k)), 32'h0b00 + 32'(k));
        check("af ndone", 32'(done_q.size() - d0), 32'd1);

        // count=0: done pulse one cycle after selection, nothing popped.
        p0 = pop_cnt[2];
        g0 = got.size();
        load(2, 16'h0c0c);
        post(3'b100, 0, 0, 0);
        tick();
        check("zero done_valid", 32'(done_valid), 32'd1);
        check("zero done_src",   32'(done_src),   32'd2);
        check("zero ren",        32'(src_ren),    32'd0);
        tick();
        check("zero idle",  32'(busy), 32'd0);
        check("zero pops",  32'(pop_cnt[2] - p0), 32'd0);
        check("zero words", 32'(got.size() - g0), 32'd0);
        check("zero left",  32'(wr_ptr[2] - rd_ptr[2]), 32'd1);

        // Reset in the middle of an 8-word drain after 3 pops.
        d0 = done_q.size();
        p0 = pop_cnt[1];
        for (int k = 0; k < 8; k++) load(1, 16'hd000 + 16'(k));
        post(3'b010, 0, 8, 0);
        for (int c = 0; c < 50 && (pop_cnt[1] - p0) < 3; c++) tick();
        check("rst pops_before", 32'(pop_cnt[1] - p0), 32'd3);
        fifo_ren = 1'b0;
        reset    = 1'b1;
        tick();
        check_idle("rst during");
        tick();
        reset    = 1'b0;
        fifo_ren = 1'b1;
        check_idle("rst after");
        repeat (3) tick();
        check("rst no_done", 32'(done_q.size() - d0), 32'd0);
        check("rst left",    32'(wr_ptr[1] - rd_ptr[1]), 32'd5);

        // The untouched remainder drains normally afterwards.
        g0 = got.size();
        post(3'b010, 0, 5, 0);
        wait_done(d0 + 1, "rst2 done_seen");
        repeat (3) tick();
        check("rst2 nwords", 32'(got.size() - g0), 32'd5);
        for (int k = 0; k < 5; k++)
            check($sformatf("rst2 word%0d", k), 32'(got_at(g0 + k)), 32'hd003 + 32'(k));
        check("rst2 done_src", 32'(done_at(d0)), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
